// File: rtl/cheshire_rst_boot_seq.sv
// Reset and boot sequencer in front of the Cheshire SoC.
//
// This block merges the power-on reset with the level-sensitive software, debug and watchdog
// reset requests. It holds the SoC in reset for RstHoldCycles after every source goes
// quiet. It then samples the boot-mode pins once, releases the SoC reset and, after
// SettleCycles, flags the boot mode as valid.
//
// Optional feature: define CHESHIRE_RST_SEQ_STICKY_CAUSE_EN to make rst_cause_o sticky across
// reset episodes, cleared only by clr_cause_i. Without it the cause register is overwritten on
// every new episode and clr_cause_i is ignored.
module cheshire_rst_boot_seq #(
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned NumRstSrc     = 3,
  parameter int unsigned CntWidth      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic [NumRstSrc-1:0] rst_req_i,
  input  logic [1:0]           boot_mode_i,
  input  logic                 clr_cause_i,
  output logic                 soc_rst_no,
  output logic [1:0]           boot_mode_o,
  output logic                 boot_mode_valid_o,
  output logic                 busy_o,
  output logic                 rst_done_o,
  output logic [NumRstSrc:0]   rst_cause_o
);

  typedef enum logic [1:0] {
    StHold,
    StSample,
    StRelease,
    StRun
  } state_e;

  localparam logic [CntWidth-1:0] CntZero    = '0;
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
  localparam logic [NumRstSrc:0]  CausePor   = (NumRstSrc + 1)'(1);

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  soc_rst_q;
  logic [1:0]            boot_mode_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NumRstSrc:0]    cause_q;

  logic                  req_any;
  logic [NumRstSrc:0]    req_cause;
  logic                  enter_hold;

  // Request decode shared by the FSM and the cause register.
  always_comb begin
    req_any    = |rst_req_i;
    req_cause  = {rst_req_i, 1'b0};
    enter_hold = req_any && (state_q != StHold);
  end

  // Sequencing FSM: hold, sample pins, release, settle, run.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StHold;
      cnt_q       <= CntZero;
      soc_rst_q   <= 1'b0;
      boot_mode_q <= 2'b00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StHold: begin
          // A held request keeps restarting the hold window.
          if (req_any) begin
            cnt_q <= CntZero;
          end else if (cnt_q == HoldLast) begin
            state_q <= StSample;
            cnt_q   <= CntZero;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StSample: begin
          if (req_any) begin
            state_q <= StHold;
            cnt_q   <= CntZero;
          end else begin
            // Pins are captured only here, once per reset episode.
            boot_mode_q <= boot_mode_i;
            soc_rst_q   <= 1'b1;
            state_q     <= StRelease;
            cnt_q       <= CntZero;
          end
        end
        StRelease: begin
          if (req_any) begin
            state_q   <= StHold;
            cnt_q     <= CntZero;
            soc_rst_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
          end else if (cnt_q == SettleLast) begin
            state_q <= StRun;
            cnt_q   <= CntZero;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRun: begin
          if (req_any) begin
            state_q   <= StHold;
            cnt_q     <= CntZero;
            soc_rst_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StHold;
          cnt_q   <= CntZero;
        end
      endcase
    end
  end

`ifdef CHESHIRE_RST_SEQ_STICKY_CAUSE_EN
  // Sticky cause: accumulate every request; clear wins over a same-cycle set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cause_q <= CausePor;
    end else if (clr_cause_i) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_q | req_cause;
    end
  end
`else
  logic unused_clr_cause;
  assign unused_clr_cause = clr_cause_i;

  // Per-episode cause: overwrite on entry to hold, accumulate while holding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cause_q <= CausePor;
    end else if (enter_hold) begin
      cause_q <= req_cause;
    end else if (state_q == StHold) begin
      cause_q <= cause_q | req_cause;
    end
  end
`endif

  // Test mode bypasses sequencing: reset and boot pins pass straight through.
  assign soc_rst_no        = test_mode_i ? rst_ni : soc_rst_q;
  assign boot_mode_o       = test_mode_i ? boot_mode_i : boot_mode_q;
  assign boot_mode_valid_o = valid_q;
  assign busy_o            = busy_q;
  assign rst_done_o        = done_q;
  assign rst_cause_o       = cause_q;

endmodule

// File: tb/tb_cheshire_rst_boot_seq.sv
// Directed, scoreboard-based bench for cheshire_rst_boot_seq with default parameters.
module tb_cheshire_rst_boot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_mode;
  logic [2:0] rst_req;
  logic [1:0] boot_mode;
  logic       clr_cause;
  logic       soc_rst_n;
  logic [1:0] boot_mode_out;
  logic       boot_valid;
  logic       busy;
  logic       rst_done;
  logic [3:0] rst_cause;

  int total = 0;
  int bad   = 0;

  typedef enum int {SigSoc, SigBoot, SigValid, SigBusy, SigDone, SigCause} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

`ifdef CHESHIRE_RST_SEQ_STICKY_CAUSE_EN
  localparam logic [3:0] CauseS3  = 4'b0101;
  localparam logic [3:0] CauseS4  = 4'b0111;
  localparam logic [3:0] CauseS5  = 4'b1111;
  localparam logic [3:0] CauseS6  = 4'b1111;
  localparam logic [3:0] CauseClr = 4'b0000;
`else
  localparam logic [3:0] CauseS3  = 4'b0100;
  localparam logic [3:0] CauseS4  = 4'b0010;
  localparam logic [3:0] CauseS5  = 4'b1000;
  localparam logic [3:0] CauseS6  = 4'b0010;
  localparam logic [3:0] CauseClr = 4'b1000;
`endif

  cheshire_rst_boot_seq dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .test_mode_i       (test_mode),
    .rst_req_i         (rst_req),
    .boot_mode_i       (boot_mode),
    .clr_cause_i       (clr_cause),
    .soc_rst_no        (soc_rst_n),
    .boot_mode_o       (boot_mode_out),
    .boot_mode_valid_o (boot_valid),
    .busy_o            (busy),
    .rst_done_o        (rst_done),
    .rst_cause_o       (rst_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observe(sig_e s);
    case (s)
      SigSoc:   return {7'd0, soc_rst_n};
      SigBoot:  return {6'd0, boot_mode_out};
      SigValid: return {7'd0, boot_valid};
      SigBusy:  return {7'd0, busy};
      SigDone:  return {7'd0, rst_done};
      default:  return {4'd0, rst_cause};
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    test_mode = 1'b0;
    rst_req   = 3'b000;
    boot_mode = 2'b10;
    clr_cause = 1'b0;

    // Reset state.
    expect_val("rst_soc", SigSoc, 8'd0);
    expect_val("rst_boot", SigBoot, 8'd0);
    expect_val("rst_valid", SigValid, 8'd0);
    expect_val("rst_busy", SigBusy, 8'd1);
    expect_val("rst_done", SigDone, 8'd0);
    expect_val("rst_cause", SigCause, 8'h1);
    tick(2);
    check_all();

    // POR sequence: release after edge 17, valid after edge 25.
    rst_n = 1'b1;
    expect_val("por_e16_soc", SigSoc, 8'd0);
    tick(16);
    check_all();
    expect_val("por_e17_soc", SigSoc, 8'd1);
    expect_val("por_e17_boot", SigBoot, 8'h2);
    expect_val("por_e17_valid", SigValid, 8'd0);
    tick(1);
    check_all();
    expect_val("por_e24_valid", SigValid, 8'd0);
    expect_val("por_e24_done", SigDone, 8'd0);
    tick(7);
    check_all();
    expect_val("por_e25_valid", SigValid, 8'd1);
    expect_val("por_e25_done", SigDone, 8'd1);
    expect_val("por_e25_busy", SigBusy, 8'd0);
    expect_val("por_e25_cause", SigCause, 8'h1);
    tick(1);
    check_all();
    // Pin change in RUN is ignored; done is a single pulse.
    boot_mode = 2'b11;
    expect_val("run_done_low", SigDone, 8'd0);
    expect_val("run_valid", SigValid, 8'd1);
    expect_val("run_boot_kept", SigBoot, 8'h2);
    tick(1);
    check_all();

    // One-cycle software request from RUN.
    rst_req = 3'b010;
    expect_val("sw_soc", SigSoc, 8'd0);
    expect_val("sw_valid", SigValid, 8'd0);
    expect_val("sw_busy", SigBusy, 8'd1);
    expect_val("sw_cause", SigCause, {4'd0, CauseS3});
    tick(1);
    check_all();
    rst_req = 3'b000;
    expect_val("sw_e16_soc", SigSoc, 8'd0);
    tick(16);
    check_all();
    expect_val("sw_e17_soc", SigSoc, 8'd1);
    expect_val("sw_e17_boot", SigBoot, 8'h3);
    tick(1);
    check_all();
    expect_val("sw_valid_on", SigValid, 8'd1);
    expect_val("sw_done_on", SigDone, 8'd1);
    tick(8);
    check_all();

    // Request held for 40 cycles keeps SoC in reset.
    rst_req = 3'b001;
    for (int i = 0; i < 40; i++) begin
      expect_val("held_soc", SigSoc, 8'd0);
      tick(1);
      check_all();
    end
    expect_val("held_cause", SigCause, {4'd0, CauseS4});
    check_all();
    rst_req = 3'b000;
    expect_val("held_e16_soc", SigSoc, 8'd0);
    tick(16);
    check_all();
    expect_val("held_e17_soc", SigSoc, 8'd1);
    tick(1);
    check_all();

    // Request at the third settle cycle with new pins.
    tick(2);
    boot_mode = 2'b01;
    rst_req   = 3'b100;
    expect_val("rel_soc", SigSoc, 8'd0);
    expect_val("rel_valid", SigValid, 8'd0);
    expect_val("rel_busy", SigBusy, 8'd1);
    expect_val("rel_boot_kept", SigBoot, 8'h3);
    expect_val("rel_cause", SigCause, {4'd0, CauseS5});
    tick(1);
    check_all();
    rst_req = 3'b000;
    expect_val("rel_e17_soc", SigSoc, 8'd1);
    expect_val("rel_e17_boot", SigBoot, 8'h1);
    tick(17);
    check_all();
    expect_val("rel_valid_on", SigValid, 8'd1);
    tick(8);
    check_all();

    // Request while in SAMPLE aborts the capture.
    rst_req = 3'b010;
    tick(1);
    rst_req   = 3'b000;
    boot_mode = 2'b10;
    tick(16);
    rst_req = 3'b001;
    expect_val("smp_soc", SigSoc, 8'd0);
    expect_val("smp_boot_kept", SigBoot, 8'h1);
    expect_val("smp_cause", SigCause, {4'd0, CauseS6});
    tick(1);
    check_all();
    rst_req = 3'b000;
    expect_val("smp_e16_soc", SigSoc, 8'd0);
    tick(16);
    check_all();
    expect_val("smp_e17_soc", SigSoc, 8'd1);
    expect_val("smp_e17_boot", SigBoot, 8'h2);
    tick(1);
    check_all();
    expect_val("smp_valid_on", SigValid, 8'd1);
    tick(8);
    check_all();

    // Clear with a simultaneous request, then clear alone while holding.
    clr_cause = 1'b1;
    rst_req   = 3'b100;
    expect_val("clr_req_cause", SigCause, {4'd0, CauseClr});
    tick(1);
    check_all();
    rst_req = 3'b000;
    expect_val("clr_only_cause", SigCause, {4'd0, CauseClr});
    tick(1);
    check_all();
    clr_cause = 1'b0;

    // New POR, then a request while holding accumulates.
    rst_n = 1'b0;
    expect_val("por2_cause", SigCause, 8'h1);
    tick(1);
    check_all();
    rst_n = 1'b1;
    tick(1);
    rst_req = 3'b100;
    expect_val("por2_req_cause", SigCause, 8'h9);
    tick(1);
    check_all();
    rst_req = 3'b000;

    // Test-mode bypass is combinational.
    test_mode = 1'b1;
    rst_n     = 1'b0;
    #1;
    expect_val("tm_soc_low", SigSoc, 8'd0);
    check_all();
    boot_mode = 2'b11;
    #1;
    expect_val("tm_boot", SigBoot, 8'h3);
    check_all();
    rst_n = 1'b1;
    #1;
    expect_val("tm_soc_high", SigSoc, 8'd1);
    check_all();
    boot_mode = 2'b00;
    rst_n     = 1'b0;
    #1;
    expect_val("tm_soc_low2", SigSoc, 8'd0);
    expect_val("tm_boot2", SigBoot, 8'h0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
